// File: rtl/input_debounce.sv
// input_debounce: multi-channel input conditioner for bouncing pad inputs.
// Each channel samples its raw input and counts consecutive samples that
// disagree with the current clean level. It accepts a new level only after
// STABLE such samples in a row. Any agreeing sample discards a partial count.
// Optional feature: define INPUT_DEBOUNCE_SYNC_EN to place a two-flop
// synchroniser in front of the counters, for asynchronous pad inputs.
// Without the macro, a single sample register is used instead, and every
// latency is one cycle shorter.
module input_debounce #(
  parameter int WIDTH  = 6,
  parameter int STABLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] clean_o,
  output logic [WIDTH-1:0] changed_o
);

  localparam int            CW       = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Output of the final sample stage, as seen by the counters.
  logic [WIDTH-1:0] sample;

`ifdef INPUT_DEBOUNCE_SYNC_EN
  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_stable;

  // Two-flop synchroniser that resolves metastability on the async pad inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta   <= '0;
      sync_stable <= '0;
    end else begin
      sync_meta   <= raw_i;
      sync_stable <= sync_meta;
    end
  end

  assign sample = sync_stable;
`else
  logic [WIDTH-1:0] sample_q;

  // Single sample register for inputs that are already synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
    end else begin
      sample_q <= raw_i;
    end
  end

  assign sample = sample_q;
`endif

  // Per-channel stability counter. It only counts while the sample disagrees
  // with the clean level, so it stays at zero in IDLE.
  logic [CW-1:0] cnt [WIDTH];

  // Per-channel debounce: count disagreeing samples, flip on the STABLE-th one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      clean_o   <= '0;
      changed_o <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sample[i] == clean_o[i]) begin
          cnt[i]       <= '0;
          changed_o[i] <= 1'b0;
        end else if (cnt[i] == CNT_LAST) begin
          clean_o[i]   <= sample[i];
          cnt[i]       <= '0;
          changed_o[i] <= 1'b1;
        end else begin
          cnt[i]       <= cnt[i] + CNT_ONE;
          changed_o[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/input_debounce.md
# input_debounce

Multi-channel input conditioner that sits directly upstream of the rising-edge detector. It synchronises raw, possibly bouncing pad inputs and releases a level change to its output only after the new level has been stable for a programmable number of consecutive clock cycles. It also flags every accepted transition with a one-cycle pulse, so the edge detector sees only clean, glitch-free levels.

## Interface

Parameters:
- WIDTH, 6: number of independent input channels.
- STABLE, 8: consecutive cycles a new sampled level must persist before it is accepted. Legal range 1..255. Counter width is $clog2(STABLE+1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- raw_i  input  WIDTH  asynchronous raw inputs, bit i = channel i.
- clean_o  output  WIDTH  debounced level per channel, registered.
- changed_o  output  WIDTH  one-cycle pulse per channel on the cycle clean_o[i] takes a new value, registered.

## Operation

- Each channel is fully independent: sampler, counter and output bit.
- Sampler: raw_i[i] passes through the sample stages (see Configuration). The last stage's value is the sample s[i].
- Per-channel counter cnt[i]:
  - if s[i] == clean_o[i]: cnt[i] <= 0; changed_o[i] <= 0.
  - else if cnt[i] == STABLE-1: clean_o[i] <= s[i]; cnt[i] <= 0; changed_o[i] <= 1.
  - else: cnt[i] <= cnt[i]+1; changed_o[i] <= 0.
- Effective states per channel: IDLE (cnt=0, s matches), COUNTING (s differs, cnt<STABLE-1), ACCEPT (flip and return to IDLE).
- Glitch rejection: a disagreement shorter than STABLE samples never reaches clean_o, and cnt clears on the first matching sample. There is no hysteresis beyond this; counts do not accumulate across interruptions.
- The counter never exceeds STABLE-1 and never wraps.
- STABLE=1: clean_o follows s with one cycle of delay, and changed_o pulses on every accepted change.
- Both directions (0->1 and 1->0) are debounced identically.
- Simultaneous changes on several channels are accepted on the same edge when their histories are identical. changed_o may have several bits set at once.

## Timing

- Reset, synchronous: on any rising edge with rst=1, all sample stages, all counters, clean_o and changed_o become 0. This takes priority over all other logic.
- Reset mid-count discards the partial count. After reset the channel restarts from clean_o=0 with empty sample stages.
- Latency is counted from the first clk edge at which the new raw level is present and then held stable:
  - with the synchroniser: clean_o changes on the (STABLE+2)th edge (10 for STABLE=8);
  - without it: on the (STABLE+1)th edge (9 for STABLE=8).
- changed_o[i] is high for exactly one cycle, coincident with the cycle in which the new clean_o[i] value first appears.
- No combinational path from raw_i to any output.

## Configuration

- INPUT_DEBOUNCE_SYNC_EN defined: a two-flop synchroniser precedes the counter, giving two sample stages. Use this for asynchronous pad inputs.
- Not defined: a single sample register, giving one sample stage. All latencies shrink by one cycle. For inputs already synchronous to clk.
- Counter and output behaviour are identical in both builds.

## Test plan

WIDTH=6, STABLE=8, macro defined unless stated.

- Reset with raw_i=6'h00, held 3 cycles -> clean_o=6'h00 and changed_o=6'h00 during and after reset.
- raw_i[0] 0->1 and held 20 cycles -> clean_o[0] rises on the 10th edge after the change, changed_o[0] is high for that one cycle only, and other bits stay 0.
- raw_i[1] high for 5 cycles then low -> clean_o[1] and changed_o[1] stay 0 throughout.
- raw_i[2] toggling every 3 cycles for 12 cycles, then held high -> clean_o[2] rises 10 edges after the final rise and pulses changed_o[2] exactly once.
- raw_i 6'h00->6'h3F, held 12 cycles, then 6'h00 held 12 cycles -> clean_o=6'h3F on the 10th edge with changed_o=6'h3F for one cycle, then back to 6'h00 10 edges after the fall with changed_o=6'h3F again.
- raw_i[3] high 5 cycles, rst=1 for one edge, raw_i[3] kept high -> clean_o[3] rises on the 10th edge after the reset edge. Repeat with the macro undefined -> on the 9th edge.
